// File: rtl/mux_bus_arbiter_if.sv
// rtl/mux_bus_arbiter_if.sv - handshake bundle between two requesters, the arbiter and one consumer
interface mux_bus_arbiter_if #(
    parameter int N = 8
);
    logic         in1_valid;
    logic [N-1:0] in1_data;
    logic         in1_ready;
    logic         in2_valid;
    logic [N-1:0] in2_data;
    logic         in2_ready;
    logic         control;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready;

    modport slave (
        input  in1_valid, in1_data, in2_valid, in2_data, out_ready,
        output in1_ready, in2_ready, control, out_valid, out_data
    );

    modport master (
        output in1_valid, in1_data, in2_valid, in2_data, out_ready,
        input  in1_ready, in2_ready, control, out_valid, out_data
    );
endinterface

// File: rtl/mux_bus_arbiter.sv
// rtl/mux_bus_arbiter.sv - round-robin 2:1 mux arbiter with a one-word registered output stage
module mux_bus_arbiter #(
    parameter int N = 8
) (
    input logic              clk,
    input logic              reset,
    mux_bus_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t       state_q, state_d;
    logic         prio_q, prio_d;
    logic         control_q, control_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_data_q, out_data_d;

    logic grant;
    logic sel;

    // Readies are held low while reset is asserted so no handshake completes during reset.
    always_comb begin
        grant = (state_q == IDLE) & ~reset & (bus.in1_valid | bus.in2_valid);
        sel   = (bus.in1_valid & bus.in2_valid) ? prio_q : bus.in2_valid;
    end

    assign bus.in1_ready = grant & bus.in1_valid & ~sel;
    assign bus.in2_ready = grant & bus.in2_valid & sel;
    assign bus.control   = control_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        control_d   = control_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    out_data_d  = sel ? bus.in2_data : bus.in1_data;
                    control_d   = sel;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // The requester that lost this grant is preferred on the next contention.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    prio_d      = ~control_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            control_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            control_q   <= control_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb/tb_mux_bus_arbiter.sv - randomized and directed bench for mux_bus_arbiter with a behavioural model
module tb_mux_bus_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mux_bus_arbiter_if #(.N(8)) bus ();

    mux_bus_arbiter #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a one-entry slot, the last granted requester, and who is favoured next.
    bit       m_full;
    bit [7:0] m_word;
    bit       m_last;
    bit       m_favour;

    function automatic int winner();
        if (reset || m_full) return -1;
        if (bus.in1_valid && bus.in2_valid) return m_favour ? 2 : 1;
        if (bus.in1_valid) return 1;
        if (bus.in2_valid) return 2;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_full   = 1'b0;
            m_word   = 8'd0;
            m_last   = 1'b0;
            m_favour = 1'b0;
        end else if (m_full) begin
            if (bus.out_ready) begin
                m_full   = 1'b0;
                m_favour = (m_last == 1'b0);
            end
        end else begin
            case (winner())
                1: begin m_full = 1'b1; m_word = bus.in1_data; m_last = 1'b0; end
                2: begin m_full = 1'b1; m_word = bus.in2_data; m_last = 1'b1; end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int w;
        w = winner();
        check("model_in1_ready", {31'd0, bus.in1_ready}, {31'd0, w == 1});
        check("model_in2_ready", {31'd0, bus.in2_ready}, {31'd0, w == 2});
        check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
        check("model_out_data",  {24'd0, bus.out_data},  {24'd0, m_word});
        check("model_control",   {31'd0, bus.control},   {31'd0, m_last});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in1_valid = 1'b0;
        bus.in2_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int k;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.in1_data = 8'd0;
        bus.in2_data = 8'd0;
        idle_inputs();

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.in1_valid = 1'($urandom);
            bus.in2_valid = 1'($urandom);
            bus.in1_data  = 8'($urandom);
            bus.in2_data  = 8'($urandom);
            bus.out_ready = 1'($urandom);
            #1;
            check("rst_control",   {31'd0, bus.control},   32'd0);
            check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_out_data",  {24'd0, bus.out_data},  32'd0);
            check("rst_readies",   {30'd0, bus.in1_ready, bus.in2_ready}, 32'd0);
        end
        cyc();
        reset = 1'b0;
        idle_inputs();

        // Single requester
        cyc();
        bus.in1_valid = 1'b1; bus.in1_data = 8'd22;
        #1;
        check("single_in1_ready", {31'd0, bus.in1_ready}, 32'd1);
        check("single_in2_ready", {31'd0, bus.in2_ready}, 32'd0);
        cyc();
        bus.in1_valid = 1'b0;
        #1;
        check("single_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("single_out_data",  {24'd0, bus.out_data},  32'd22);
        check("single_control",   {31'd0, bus.control},   32'd0);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        #1;
        check("single_drain", {31'd0, bus.out_valid}, 32'd0);

        // Contention from a fresh reset, consumer always ready
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.in1_valid = 1'b1; bus.in1_data = 8'd70;
        bus.in2_valid = 1'b1; bus.in2_data = 8'd17;
        bus.out_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            #1;
            if (bus.out_valid) begin
                check("cont_data", {24'd0, bus.out_data}, (k % 2) ? 32'd17 : 32'd70);
                check("cont_control", {31'd0, bus.control}, (k % 2) ? 32'd1 : 32'd0);
                k++;
            end
        end
        check("cont_words_seen", k, 32'd4);

        // Backpressure on an in2 grant
        idle_inputs();
        bus.in2_valid = 1'b1; bus.in2_data = 8'd14;
        cyc();
        bus.in1_valid = 1'b1; bus.in1_data = 8'd99;
        #1;
        check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            check("bp_data",    {24'd0, bus.out_data}, 32'd14);
            check("bp_control", {31'd0, bus.control},  32'd1);
            check("bp_readies", {30'd0, bus.in1_ready, bus.in2_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        cyc();
        idle_inputs();
        #1;
        check("bp_release", {31'd0, bus.out_valid}, 32'd0);

        // Reset during HOLD
        bus.in2_valid = 1'b1; bus.in2_data = 8'd17;
        cyc();
        bus.in2_valid = 1'b0;
        #1;
        check("mid_hold_data", {24'd0, bus.out_data}, 32'd17);
        reset = 1'b1;
        #1;
        check("mid_rst_valid",   {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_data",    {24'd0, bus.out_data},  32'd0);
        check("mid_rst_control", {31'd0, bus.control},   32'd0);
        cyc();
        reset = 1'b0;
        bus.in1_valid = 1'b1; bus.in1_data = 8'd5;
        bus.in2_valid = 1'b1; bus.in2_data = 8'd9;
        #1;
        check("post_rst_in1_ready", {31'd0, bus.in1_ready}, 32'd1);
        check("post_rst_in2_ready", {31'd0, bus.in2_ready}, 32'd0);
        cyc();
        idle_inputs();
        #1;
        check("post_rst_data", {24'd0, bus.out_data}, 32'd5);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // Late arrival of in1 during an in2 hold
        bus.in2_valid = 1'b1; bus.in2_data = 8'd33;
        cyc();
        bus.in2_valid = 1'b0;
        #1;
        check("late_first", {24'd0, bus.out_data}, 32'd33);
        bus.in1_valid = 1'b1; bus.in1_data = 8'd44;
        bus.in2_valid = 1'b1; bus.in2_data = 8'd55;
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        #1;
        check("late_in1_ready", {31'd0, bus.in1_ready}, 32'd1);
        check("late_in2_ready", {31'd0, bus.in2_ready}, 32'd0);
        cyc();
        bus.in1_valid = 1'b0;
        #1;
        check("late_in1_word", {24'd0, bus.out_data}, 32'd44);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        #1;
        check("late_in2_ready_after", {31'd0, bus.in2_ready}, 32'd1);
        cyc();
        idle_inputs();
        #1;
        check("late_in2_word",    {24'd0, bus.out_data}, 32'd55);
        check("late_in2_control", {31'd0, bus.control},  32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset         = ($urandom_range(0, 249) == 0);
            bus.in1_valid = ($urandom_range(0, 3) != 0);
            bus.in2_valid = ($urandom_range(0, 3) != 0);
            bus.in1_data  = 8'($urandom);
            bus.in2_data  = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        cyc();
        reset = 1'b0;
        idle_inputs();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
